interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter MASK_PORT_ID, 8'hF0: port ID whose OUT write loads the MASK register.
REQ-002 Parameter CLR_PORT_ID, 8'hF1: port ID whose OUT write clears PENDING bits (write-1-to-clear).
REQ-003 Parameter STAT_PORT_ID, 8'hF2: port ID whose IN read returns PENDING.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 IRQ  in  8  asynchronous interrupt sources; index 0 has highest priority.
REQ-007 INT_ACK  in  1  one-cycle strobe from the control unit when it takes the interrupt.
REQ-008 INT_DONE  in  1  one-cycle strobe from the control unit when RETI executes.
REQ-009 IO_STRB  in  1  OUT-instruction write strobe.
REQ-010 PORT_ID  in  8  I/O port address.
REQ-011 OUT_PORT  in  8  I/O write data.
REQ-012 INT  out  1  registered interrupt request to the control unit.
REQ-013 INT_ID  out  3  registered index of the requested or serviced source.
REQ-014 BUSY  out  1  high while an interrupt is in service.
REQ-015 IN_DATA  out  8  PENDING when PORT_ID==STAT_PORT_ID, else 8'h00 (combinational).

Function
REQ-016 Each IRQ bit SHALL pass a two-flop synchronizer, then a rising-edge detector (synchronized value high, previous low).
REQ-017 A detected edge SHALL set PENDING[i] at the next edge; IRQ first sampled high at edge k gives PENDING[i]=1 after edge k+2.
REQ-018 Level-held IRQ SHALL produce exactly one pending event.
REQ-019 IO_STRB with PORT_ID==MASK_PORT_ID SHALL load MASK<=OUT_PORT; with PORT_ID==CLR_PORT_ID SHALL clear PENDING bits where OUT_PORT is 1.
REQ-020 Same-cycle set and clear of a PENDING bit (edge vs. ACK or CLR write): set wins.
REQ-021 FSM states: IDLE, REQ, SERVICE.
REQ-022 IDLE: if (PENDING & MASK)!=0, go to REQ and latch INT_ID = lowest set index of (PENDING & MASK).
REQ-023 REQ: INT=1; on INT_ACK, clear PENDING[INT_ID] and go to SERVICE.
REQ-024 REQ: if MASK[INT_ID] becomes 0 before INT_ACK, return to IDLE with INT=0 and PENDING unchanged.
REQ-025 SERVICE: INT=0, BUSY=1; on INT_DONE go to IDLE. New edges keep accumulating in PENDING; no nesting.
REQ-026 INT_ACK outside REQ and INT_DONE outside SERVICE SHALL be ignored.
REQ-027 INT SHALL be a registered state decode (no combinational path from IRQ); latency from IRQ first sample at edge k to INT=1 is after edge k+3.
REQ-028 INT_ID SHALL stay stable from entry into REQ until the return to IDLE.

Reset
REQ-029 RESET SHALL force state IDLE, MASK=0, PENDING=0, synchronizer/edge flops=0, INT=0, INT_ID=0, BUSY=0 at the next edge.
REQ-030 Reset mid-service SHALL abandon the service without requiring INT_DONE.
REQ-031 An IRQ held high through reset SHALL register as a new edge after reset.

Structure
REQ-032 A shared package SHALL hold the state enum and the three port-ID defaults.
REQ-033 One sub-module, irq_edge_sync (synchronizer plus edge detector, one bit), SHALL be instantiated 8 times.

Verification
REQ-034 MASK=8'h01, pulse IRQ[0] -> INT=1 after edge k+3, INT_ID=0; INT_ACK -> BUSY=1, PENDING=0; INT_DONE -> IDLE.
REQ-035 MASK=8'hFF, IRQ[5] and IRQ[2] rise same cycle -> INT_ID=2 first; after INT_DONE, INT_ID=5 requested.
REQ-036 MASK=0, pulse IRQ[3] -> no INT, IN_DATA=8'h08 at STAT_PORT_ID; write MASK=8'h08 -> INT=1, INT_ID=3.
REQ-037 In REQ for ID 4, write MASK=0 -> INT drops, state IDLE, PENDING[4] still 1.
REQ-038 IRQ[1] edge lands on the same cycle as INT_ACK for ID 1 -> PENDING[1] remains 1; second request follows INT_DONE.
REQ-039 RESET asserted in SERVICE with IRQ[6] held high -> all outputs 0 after edge; after release, PENDING[6] sets once.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared types and defaults for the 8-source interrupt controller.
// Holds the FSM state encoding, default I/O port IDs and a priority helper.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam logic [7:0] MASK_PORT_ID_DEF = 8'hF0;
    localparam logic [7:0] CLR_PORT_ID_DEF  = 8'hF1;
    localparam logic [7:0] STAT_PORT_ID_DEF = 8'hF2;

    localparam int NUM_IRQ = 8;

    // Index 0 is the highest priority, so the lowest set bit wins.
    function automatic logic [2:0] lowest_set_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_edge.sv
// One interrupt line: two-flop synchronizer followed by a rising-edge detector.
// rise is high for exactly one cycle per low-to-high transition of the synchronized input.
module irq_edge_sync
    import interrupt_controller_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic sync_meta;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            sync_meta <= irq;
            sync_q    <= sync_meta;
            prev_q    <= sync_q;
        end
    end

    // Clearing prev_q in reset makes a level held through reset count as a new edge.
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Eight-source prioritized interrupt controller with MASK / write-1-to-clear / status ports.
// States: IDLE = nothing requested | REQ = INT raised, awaiting ack | SERVICE = handler running, awaiting RETI.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [7:0] MASK_PORT_ID = MASK_PORT_ID_DEF,
    parameter logic [7:0] CLR_PORT_ID  = CLR_PORT_ID_DEF,
    parameter logic [7:0] STAT_PORT_ID = STAT_PORT_ID_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IRQ,
    input  logic       INT_ACK,
    input  logic       INT_DONE,
    input  logic       IO_STRB,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic       INT,
    output logic [2:0] INT_ID,
    output logic       BUSY,
    output logic [7:0] IN_DATA
);

    irq_state_t state;
    logic [7:0] mask;
    logic [7:0] pending;
    logic [7:0] pending_next;
    logic [7:0] rise_vec;
    logic [7:0] clr_vec;
    logic [7:0] masked;
    logic       mask_wr;
    logic       clr_wr;
    logic       ack_take;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_edge_sync u_edge (
            .clk   (CLK),
            .reset (RESET),
            .irq   (IRQ[g]),
            .rise  (rise_vec[g])
        );
    end

    assign mask_wr  = IO_STRB && (PORT_ID == MASK_PORT_ID);
    assign clr_wr   = IO_STRB && (PORT_ID == CLR_PORT_ID);
    assign ack_take = (state == ST_REQ) && INT_ACK;
    assign masked   = pending & mask;

    always_comb begin
        clr_vec = 8'h00;
        if (clr_wr) begin
            clr_vec = clr_vec | OUT_PORT;
        end
        if (ack_take) begin
            clr_vec = clr_vec | (8'h01 << INT_ID);
        end
    end

    // A fresh edge is ORed in after the clear so a coincident set always wins.
    assign pending_next = (pending & ~clr_vec) | rise_vec;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mask    <= 8'h00;
            pending <= 8'h00;
        end else begin
            if (mask_wr) begin
                mask <= OUT_PORT;
            end
            pending <= pending_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            INT    <= 1'b0;
            INT_ID <= 3'd0;
            BUSY   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    BUSY <= 1'b0;
                    if (|masked) begin
                        state  <= ST_REQ;
                        INT    <= 1'b1;
                        INT_ID <= lowest_set_index(masked);
                    end else begin
                        INT <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (INT_ACK) begin
                        state <= ST_SERVICE;
                        INT   <= 1'b0;
                        BUSY  <= 1'b1;
                    end else if (!mask[INT_ID]) begin
                        // Request withdrawn; pending bit stays so it can be re-requested later.
                        state <= ST_IDLE;
                        INT   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    INT <= 1'b0;
                    if (INT_DONE) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    INT   <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    assign IN_DATA = (PORT_ID == STAT_PORT_ID) ? pending : 8'h00;

endmodule
